// File: rtl/sobel_pkg.sv
// Shared constants for the streaming 3x3 Sobel edge detector.
package sobel_pkg;

   typedef enum logic [1:0] {
      MODE_MAG    = 2'd0,
      MODE_THRESH = 2'd1,
      MODE_GX     = 2'd2,
      MODE_GY     = 2'd3
   } mode_e;

   localparam int LATENCY = 4;

   function automatic int GRAD_W(input int pixel_w);
      return pixel_w + 3;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: simple dual-port RAM, registered read, read-before-write.
module sobel_line_buffer #(
   parameter  int PIXEL_W  = 8,
   parameter  int MAX_COLS = 720,
   localparam int AW       = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1
) (
   input  logic               clk,
   input  logic               we_i,
   input  logic [AW-1:0]      waddr_i,
   input  logic [PIXEL_W-1:0] wdata_i,
   input  logic               re_i,
   input  logic [AW-1:0]      raddr_i,
   output logic [PIXEL_W-1:0] rdata_o
);

   logic [PIXEL_W-1:0] mem [MAX_COLS];
   logic [PIXEL_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (re_i) rdata_q <= mem[raddr_i];
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sobel_filter_3x3.sv
// Streaming 3x3 Sobel edge detector: S0 line-buffer read, S1 window shift,
// S2 gradients, S3 output select; one output per input pixel, 4 cycles later.
module sobel_filter_3x3
   import sobel_pkg::*;
#(
   parameter int PIXEL_W  = 8,
   parameter int MAX_COLS = 720,
   parameter int COL_W    = 10,
   parameter int LATENCY  = sobel_pkg::LATENCY
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_valid,
   input  logic               sof,
   input  logic               sol,
   input  logic [PIXEL_W-1:0] pix_in,
   input  logic [1:0]         mode,
   input  logic [PIXEL_W-1:0] threshold,
   output logic               out_valid,
   output logic               out_sof,
   output logic               out_sol,
   output logic [PIXEL_W-1:0] pix_out,
   output logic               overflow
);

   localparam int GW = GRAD_W(PIXEL_W);
   localparam int MW = PIXEL_W + 4;
   localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(MAX_COLS);
   localparam logic [MW-1:0]    PIX_MAX = MW'({PIXEL_W{1'b1}});

   logic [COL_W-1:0]   col_q, col_d, col_cur;
   logic [1:0]         row_q, row_d, row_cur;
   logic               ovf_q, ovf_d;
   logic               in_range, zero_s0, lb_en;
   logic [PIXEL_W-1:0] lb0_rd, lb1_rd, pix_s1_q;
   logic               lb1_we_q;
   logic [AW-1:0]      lb1_wa_q;
   logic [LATENCY-1:0] vld_q, sof_q, sol_q;
   logic [2:0]         zero_q;
   logic [2:0][2:0][PIXEL_W-1:0] win_q;
   logic [GW-1:0]        gx_p, gx_n, gy_p, gy_n, ax, ay;
   logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
   logic [MW-1:0]        mag;
   logic [PIXEL_W-1:0]   mag_sat, pix_d, pix_q;

   function automatic logic [PIXEL_W-1:0] sat(input logic [MW-1:0] v);
      return (v > PIX_MAX) ? {PIXEL_W{1'b1}} : v[PIXEL_W-1:0];
   endfunction

   // Position of the current pixel; the row count only needs to reach 2.
   always_comb begin
      col_cur = (sof || sol) ? '0 : col_q;
      row_cur = row_q;
      if (sof)                       row_cur = 2'd0;
      else if (sol && row_q != 2'd2) row_cur = row_q + 2'd1;
      in_range = col_cur < COL_MAX;
      zero_s0  = (row_cur != 2'd2) || (col_cur < COL_W'(2)) || !in_range;
      lb_en    = pix_valid && in_range;
      col_d = col_q;
      row_d = row_q;
      ovf_d = ovf_q;
      if (pix_valid) begin
         col_d = in_range ? col_cur + COL_W'(1) : COL_MAX;
         row_d = row_cur;
         if (sof)       ovf_d = 1'b0;
         if (!in_range) ovf_d = 1'b1;
      end
   end

   // lb1 takes lb0's old word one cycle later, so rows r-1/r-2 roll down together.
   sobel_line_buffer #(.PIXEL_W(PIXEL_W), .MAX_COLS(MAX_COLS)) u_lb0 (
      .clk     (clk),
      .we_i    (lb_en),
      .waddr_i (col_cur[AW-1:0]),
      .wdata_i (pix_in),
      .re_i    (lb_en),
      .raddr_i (col_cur[AW-1:0]),
      .rdata_o (lb0_rd)
   );

   sobel_line_buffer #(.PIXEL_W(PIXEL_W), .MAX_COLS(MAX_COLS)) u_lb1 (
      .clk     (clk),
      .we_i    (lb1_we_q),
      .waddr_i (lb1_wa_q),
      .wdata_i (lb0_rd),
      .re_i    (lb_en),
      .raddr_i (col_cur[AW-1:0]),
      .rdata_o (lb1_rd)
   );

   always_comb begin
      gx_p = GW'(win_q[0][2]) + (GW'(win_q[1][2]) << 1) + GW'(win_q[2][2]);
      gx_n = GW'(win_q[0][0]) + (GW'(win_q[1][0]) << 1) + GW'(win_q[2][0]);
      gy_p = GW'(win_q[2][0]) + (GW'(win_q[2][1]) << 1) + GW'(win_q[2][2]);
      gy_n = GW'(win_q[0][0]) + (GW'(win_q[0][1]) << 1) + GW'(win_q[0][2]);
      gx_d = signed'(gx_p - gx_n);
      gy_d = signed'(gy_p - gy_n);
   end

   always_comb begin
      ax      = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
      ay      = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
      mag     = MW'(ax) + MW'(ay);
      mag_sat = sat(mag);
      pix_d   = '0;
      if (!zero_q[2]) begin
         case (mode_e'(mode))
            MODE_MAG:    pix_d = mag_sat;
            MODE_THRESH: pix_d = (mag_sat >= threshold) ? {PIXEL_W{1'b1}} : '0;
            MODE_GX:     pix_d = sat(MW'(ax));
            MODE_GY:     pix_d = sat(MW'(ay));
            default:     pix_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q    <= '0;
         row_q    <= '0;
         ovf_q    <= 1'b0;
         vld_q    <= '0;
         sof_q    <= '0;
         sol_q    <= '0;
         zero_q   <= '0;
         lb1_we_q <= 1'b0;
         lb1_wa_q <= '0;
         pix_s1_q <= '0;
         win_q    <= '0;
         gx_q     <= '0;
         gy_q     <= '0;
         pix_q    <= '0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         ovf_q    <= ovf_d;
         vld_q    <= {vld_q[LATENCY-2:0], pix_valid};
         sof_q    <= {sof_q[LATENCY-2:0], pix_valid & sof};
         sol_q    <= {sol_q[LATENCY-2:0], pix_valid & sol};
         lb1_we_q <= lb_en;
         lb1_wa_q <= col_cur[AW-1:0];
         if (pix_valid) begin
            pix_s1_q  <= pix_in;
            zero_q[0] <= zero_s0;
         end
         if (vld_q[0]) begin
            for (int r = 0; r < 3; r++) begin
               win_q[r][0] <= win_q[r][1];
               win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= lb1_rd;
            win_q[1][2] <= lb0_rd;
            win_q[2][2] <= pix_s1_q;
            zero_q[1]   <= zero_q[0];
         end
         if (vld_q[1]) begin
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            zero_q[2] <= zero_q[1];
         end
         if (vld_q[2]) pix_q <= pix_d;
      end
   end

   assign out_valid = vld_q[LATENCY-1];
   assign out_sof   = sof_q[LATENCY-1];
   assign out_sol   = sol_q[LATENCY-1];
   assign pix_out   = pix_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_sobel_filter_3x3.sv
// Bench for sobel_filter_3x3: image-level reference model plus table and hand sequences.
module tb_sobel_filter_3x3;
   import sobel_pkg::*;

   localparam int PW   = 8;
   localparam int MC   = 16;
   localparam int CW   = 5;
   localparam int PMAX = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          pix_valid, sof, sol;
   logic [PW-1:0] pix_in, threshold;
   logic [1:0]    mode;
   logic          out_valid, out_sof, out_sol, overflow;
   logic [PW-1:0] pix_out;

   always #5 clk = ~clk;

   sobel_filter_3x3 #(.PIXEL_W(PW), .MAX_COLS(MC), .COL_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .pix_valid (pix_valid),
      .sof       (sof),
      .sol       (sol),
      .pix_in    (pix_in),
      .mode      (mode),
      .threshold (threshold),
      .out_valid (out_valid),
      .out_sof   (out_sof),
      .out_sol   (out_sol),
      .pix_out   (pix_out),
      .overflow  (overflow)
   );

   typedef struct {
      int gx; int gy; bit zero; bit f; bit l; int r; int c;
   } exp_t;

   typedef struct {
      logic [1:0] md; int thr; int edge_v;
   } vec_t;

   int       n_cmp = 0, n_bad = 0;
   exp_t     q[$];
   int       img[0:15][0:MC-1];
   int       out_img[0:15][0:31];
   int       mr, mc;
   bit       m_ovf;
   bit [3:0] vhist;
   logic [1:0] cur_mode;
   int       cur_thr;
   bit       chk_en;
   int       last_pix;
   exp_t     ck_e;
   int       ck_ev;
   vec_t     tbl[5];

   task automatic check(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      vhist = '0;
      mr = 0; mc = 0; m_ovf = 0;
   endtask

   // Whole-image view: gradients come straight from the stored frame pixels.
   task automatic model_push(input bit f, input bit l, input int p);
      exp_t e;
      int   w;
      if (f) begin mr = 0; m_ovf = 0; end
      else if (l) mr++;
      if (f || l) mc = 0;
      e.f = f; e.l = l; e.r = mr; e.c = mc; e.gx = 0; e.gy = 0;
      e.zero = (mr < 2) || (mc < 2) || (mc >= MC);
      if (mc < MC) img[mr][mc] = p;
      else m_ovf = 1;
      if (!e.zero) begin
         for (int i = 0; i < 3; i++) begin
            w = (i == 1) ? 2 : 1;
            e.gx += w * (img[mr-2+i][mc] - img[mr-2+i][mc-2]);
            e.gy += w * (img[mr][mc-2+i] - img[mr-2][mc-2+i]);
         end
      end
      q.push_back(e);
      mc++;
   endtask

   function automatic int exp_val(input exp_t e, input logic [1:0] md, input int thr);
      int ax, ay, mag;
      if (e.zero) return 0;
      ax  = (e.gx < 0) ? -e.gx : e.gx;
      ay  = (e.gy < 0) ? -e.gy : e.gy;
      mag = ax + ay;
      if (mag > PMAX) mag = PMAX;
      case (md)
         2'd0:    return mag;
         2'd1:    return (mag >= thr) ? PMAX : 0;
         2'd2:    return (ax > PMAX) ? PMAX : ax;
         default: return (ay > PMAX) ? PMAX : ay;
      endcase
   endfunction

   task automatic cyc(input bit v, input bit f, input bit l, input int p);
      pix_valid = v; sof = f; sol = l; pix_in = p[PW-1:0];
      @(posedge clk);
      vhist    = {vhist[2:0], v};
      cur_mode = mode;
      cur_thr  = int'(threshold);
      if (v) model_push(f, l, p);
      @(negedge clk);
   endtask

   task automatic flush();
      repeat (6) cyc(0, 0, 0, 0);
   endtask

   task automatic clear_out();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 32; c++) out_img[r][c] = -1;
   endtask

   function automatic int pixval(input int kind, input int r, input int c);
      case (kind)
         0:       return 100;
         1:       return (c < 4) ? 0 : 255;
         2:       return (r < 2) ? 0 : 10;
         default: return int'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic send_frame(input int w, input int h, input int kind, input bit gaps, input bit sw);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            if (gaps && $urandom_range(0, 3) == 0)
               cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            if (sw) mode = (r == 3 && c == 7) ? MODE_GX : MODE_GY;
            cyc(1, r == 0 && c == 0, c == 0, pixval(kind, r, c));
         end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", int'(out_valid), int'(vhist[3]));
         check("overflow", int'(overflow), int'(m_ovf));
         if (out_valid) begin
            if (q.size() == 0) check("unexpected_out", q.size(), 1);
            else begin
               ck_e  = q.pop_front();
               ck_ev = exp_val(ck_e, cur_mode, cur_thr);
               check("pix_out", int'(pix_out), ck_ev);
               check("out_sof", int'(out_sof), int'(ck_e.f));
               check("out_sol", int'(out_sol), int'(ck_e.l));
               if (ck_e.r < 16 && ck_e.c < 32) out_img[ck_e.r][ck_e.c] = int'(pix_out);
            end
         end else begin
            check("pix_hold", int'(pix_out), last_pix);
         end
      end
      last_pix = int'(pix_out);
   end

   initial begin
      int w, h;
      reset = 1'b0; pix_valid = 0; sof = 0; sol = 0; pix_in = '0;
      mode = MODE_MAG; threshold = '0; chk_en = 0; cur_mode = MODE_MAG; cur_thr = 0;
      model_reset();
      clear_out();
      tbl[0] = '{MODE_MAG,    0,  40};
      tbl[1] = '{MODE_THRESH, 40, 255};
      tbl[2] = '{MODE_THRESH, 41, 0};
      tbl[3] = '{MODE_GX,     0,  0};
      tbl[4] = '{MODE_GY,     0,  40};

      #1;
      check("rst_valid", int'(out_valid), 0);
      check("rst_pix", int'(pix_out), 0);
      check("rst_ovf", int'(overflow), 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      chk_en = 1;

      // flat frame
      clear_out();
      send_frame(8, 5, 0, 0, 0);
      flush();
      check("flat_r3c5", out_img[3][5], 0);
      check("flat_r4c7", out_img[4][7], 0);

      // vertical step
      clear_out();
      send_frame(8, 5, 1, 0, 0);
      flush();
      for (int r = 2; r < 5; r++) begin
         check("vstep_c4", out_img[r][4], 255);
         check("vstep_c5", out_img[r][5], 255);
         check("vstep_c3", out_img[r][3], 0);
         check("vstep_c6", out_img[r][6], 0);
      end

      // horizontal step under each mode
      for (int i = 0; i < 5; i++) begin
         mode = tbl[i].md; threshold = PW'(tbl[i].thr);
         clear_out();
         send_frame(8, 5, 2, 0, 0);
         flush();
         check("hstep_r2", out_img[2][4], tbl[i].edge_v);
         check("hstep_r3", out_img[3][5], tbl[i].edge_v);
         check("hstep_r4", out_img[4][4], 0);
         check("hstep_r1", out_img[1][4], 0);
      end

      // mode switch for exactly one output cycle
      clear_out();
      send_frame(8, 5, 2, 0, 1);
      flush();
      check("msw_hit", out_img[3][4], 0);
      check("msw_before", out_img[3][3], 40);
      check("msw_after", out_img[3][5], 40);

      // random frames with bubbles, ignored tags, truncated last lines
      for (int f = 0; f < 12; f++) begin
         w = int'($urandom_range(3, MC));
         h = int'($urandom_range(3, 8));
         mode = 2'($urandom_range(0, 3));
         threshold = PW'($urandom_range(0, 255));
         send_frame(w, h, 3, 1, 0);
         if (f[0]) for (int c = 0; c < int'($urandom_range(1, w - 1)); c++)
            cyc(1, 0, c == 0, int'($urandom_range(0, 255)));
      end
      flush();

      // line overflow
      mode = MODE_MAG;
      clear_out();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < MC; c++) cyc(1, r == 0 && c == 0, c == 0, int'($urandom_range(0, 255)));
      for (int c = 0; c < MC + 3; c++) begin
         cyc(1, 0, c == 0, int'($urandom_range(0, 255)));
         check("ovf_rise", int'(overflow), int'(c >= MC));
      end
      flush();
      check("ovf_tail0", out_img[3][MC], 0);
      check("ovf_tail1", out_img[3][MC+1], 0);
      check("ovf_tail2", out_img[3][MC+2], 0);

      // asynchronous reset in the middle of a busy line
      for (int c = 0; c < 6; c++) cyc(1, 0, c == 0, int'($urandom_range(1, 255)));
      chk_en = 0;
      #2 reset = 1'b0;
      #1;
      check("amid_valid", int'(out_valid), 0);
      check("amid_pix", int'(pix_out), 0);
      check("amid_ovf", int'(overflow), 0);
      for (int i = 0; i < 4; i++) begin
         pix_valid = ~pix_valid; sof = i[0]; sol = 1'b1; pix_in = 8'hA5;
         @(negedge clk);
         check("rst_hold_valid", int'(out_valid), 0);
      end
      model_reset();
      reset = 1'b1;
      chk_en = 1;
      for (int i = 0; i < 5; i++) begin
         cyc(1, i == 0, i == 0, 50 + i);
         check("latency", int'(out_valid), int'(i >= 3));
      end

      // overflow then clear on the next sof
      for (int c = 0; c < MC + 1; c++) cyc(1, 0, c == 0, int'($urandom_range(0, 255)));
      check("ovf_set", int'(overflow), 1);
      cyc(1, 1, 1, 7);
      check("ovf_clear", int'(overflow), 0);
      flush();

      check("drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sobel_filter_3x3.md
Name: sobel_filter_3x3

Overview:
Parametrised streaming 3x3 Sobel edge detector for the NTSC capture path.
- Sits after the luma extractor and before the frame-buffer writer.
- Accepts one greyscale pixel per qualified cycle, tagged with start-of-frame and start-of-line.
- Emits one edge pixel per input pixel at a fixed latency.
- Adds four things a single-mode detector lacks: parametrised pixel width and line length, selectable output mode, programmable threshold, and border and line-overflow handling.

Parameters:
PIXEL_W, 8, bits per input and output pixel
MAX_COLS, 720, line-buffer depth; maximum active pixels per line
COL_W, 10, column counter width; must satisfy 2^COL_W > MAX_COLS
LATENCY, 4, fixed input-to-output delay in clk cycles; informational, must not be overridden

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
pix_valid  input  1  pix_in and the sof/sol tags are valid this cycle
sof  input  1  first pixel of frame; implies sol; qualified by pix_valid
sol  input  1  first pixel of line; qualified by pix_valid
pix_in  input  PIXEL_W  greyscale pixel
mode  input  2  0 MAG, 1 THRESH, 2 GX, 3 GY
threshold  input  PIXEL_W  compare level for THRESH mode
out_valid  output  1  pix_out valid
out_sof  output  1  sof delayed by LATENCY
out_sol  output  1  sol delayed by LATENCY
pix_out  output  PIXEL_W  edge result
overflow  output  1  sticky: a line exceeded MAX_COLS

Behaviour:
- Reset (asserted low, asynchronous):
  - Clears out_valid, out_sof, out_sol, pix_out, overflow, col/row counters and all pipeline valid bits.
  - Line-buffer RAM contents are not cleared; the row gate makes stale data invisible.
- Counters:
  - col (COL_W bits): loads 0 on a valid pixel with sol, else increments per valid pixel; saturates at MAX_COLS.
  - row (2-bit): loads 0 on sof; increments on sol without sof; saturates at 2.
- Line buffers: two instances of depth MAX_COLS, holding rows r-1 and r-2.
  - Written at address col on a valid pixel when col < MAX_COLS.
  - Read-before-write at the same address.
- Window: 3x3 shift register, advanced only on valid pixels; centre = pixel (r-1, c-1).
- Pipeline (exactly 4 cycles, pix_valid -> out_valid; bubbles propagate, no backpressure):
  - S0: line-buffer read.
  - S1: window shift.
  - S2: gradient compute.
    - Gx = (p02+2p12+p22) - (p00+2p10+p20).
    - Gy = (p20+2p21+p22) - (p00+2p01+p02).
    - Signed, PIXEL_W+3 bits.
  - S3: output select.
    - mag = |Gx|+|Gy|, PIXEL_W+4 bits, saturated to 2^PIXEL_W-1.
    - MAG: mag_sat.
    - THRESH: all-ones if mag_sat >= threshold, else 0.
    - GX: |Gx| saturated.
    - GY: |Gy| saturated.
- mode and threshold are sampled at S3; a change affects the next output cycle with no glitch in the current one.
- Border: pix_out = 0 when row < 2 or col < 2 at window completion. The output image is the input shifted by one row and one column, with a zero border.
- Overflow: a valid pixel with col >= MAX_COLS produces pix_out = 0, no RAM write, and sets overflow. overflow clears on the next valid sof.
- sof mid-line: counters restart immediately; the in-flight pipeline drains normally.
- sol and sof asserted without pix_valid are ignored.
- When out_valid = 0, pix_out holds its last value.

Decomposition:
- Package sobel_pkg:
  - mode constants MODE_MAG=0, MODE_THRESH=1, MODE_GX=2, MODE_GY=3;
  - LATENCY=4;
  - gradient width function GRAD_W(PIXEL_W)=PIXEL_W+3.
- Sub-module sobel_line_buffer (parameters PIXEL_W, MAX_COLS): single-clock simple dual-port RAM with registered read and read-before-write; instantiated twice.

Test Plan:
1. Hold reset low mid-line with pix_valid toggling -> out_valid=0, pix_out=0, overflow=0 immediately. Release, send a fresh sof -> first output at exactly 4 cycles.
2. 8x5 frame, all pixels 100, mode MAG -> every pix_out=0; out_valid is pix_valid delayed 4; out_sof/out_sol align with input tags +4.
3. 8x5 frame, columns 0-3 =0, columns 4-7 =255, mode MAG -> on rows >= 2, outputs for centres col 3 and col 4 are 255 (Gx=1020, saturated); all others 0.
4. Horizontal step, rows 0-1 =0, rows 2-4 =10, THRESH mode:
   - threshold=40 -> edge outputs 255 (Gy=40);
   - threshold=41 -> 0.
5. Same image in mode GX -> all 0; mode GY -> 40. Switch mode between two pixels -> the change appears on the corresponding output cycle only.
6. Line of MAX_COLS+3 pixels -> overflow rises with pixel index MAX_COLS, the last 3 outputs are 0, and the next sof clears overflow.
